// File: rtl/tinuc_hazard_ctrl.sv
// TinuC pipeline control: bank enables/clears, EX forwarding, stall/flush counters.
// Build option: TINUC_FWD_EN selects operand forwarding instead of RAW bubbles.
module tinuc_hazard_ctrl #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int BR_STAGE = 3,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic [XLEN-1:0]   wb_result,
  input  logic [XLEN-1:0]   ex_rdata1,
  input  logic [XLEN-1:0]   ex_rdata2,
  input  logic              branch_taken,
  input  logic              dmem_wait,
  output logic [XLEN-1:0]   fw_a,
  output logic [XLEN-1:0]   fw_b,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              pc_sel,
  output logic              ifid_clr,
  output logic              idex_clr,
  output logic              exmem_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [2:0] {
    RUN, LD_STALL, RAW_STALL, FLUSH, MEM_WAIT
  } state_t;

  state_t state, nxt;
  logic   ld_use, raw, stall_inc, flush_inc;

  function automatic logic id_hit(
    input logic [REG_AW-1:0] rd,
    input logic              we
  );
    return we && (rd != '0) &&
      ((id_use_rs1 && rd == id_rs1) ||
       (id_use_rs2 && rd == id_rs2));
  endfunction

  assign ld_use = id_hit(ex_rd, ex_memread);

`ifdef TINUC_FWD_EN
  function automatic logic [XLEN-1:0] fwd(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rf
  );
    if (mem_regwrite && mem_rd != '0 && mem_rd == rs)
      return mem_result;
    else if (wb_regwrite && wb_rd != '0 && wb_rd == rs)
      return wb_result;
    else
      return rf;
  endfunction

  assign fw_a = fwd(ex_rs1, ex_rdata1);
  assign fw_b = fwd(ex_rs2, ex_rdata2);
  assign raw  = 1'b0;

  logic unused_st;
  assign unused_st = ^{state, ex_regwrite};
`else
  logic       raw_hit;
  logic [1:0] raw_q, raw_prev;

  assign fw_a = ex_rdata1;
  assign fw_b = ex_rdata2;

  assign raw_hit = id_hit(ex_rd, ex_regwrite) |
                   id_hit(mem_rd, mem_regwrite) |
                   id_hit(wb_rd, wb_regwrite);

  // consecutive RAW bubbles issued so far; capped at three
  assign raw_prev = (state == RAW_STALL) ? raw_q : 2'd0;
  assign raw      = raw_hit && (raw_prev != 2'd3);

  always_ff @(posedge CLK) begin
    if (RESET)
      raw_q <= 2'd0;
    else if (nxt == RAW_STALL)
      raw_q <= raw_prev + 2'd1;
    else
      raw_q <= 2'd0;
  end

  logic unused_fwd;
  assign unused_fwd = ^{mem_result, wb_result, ex_rs1, ex_rs2};
`endif

  always_comb begin
    nxt       = RUN;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    pc_sel    = 1'b0;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (RESET) begin
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
    end else if (dmem_wait) begin
      nxt       = MEM_WAIT;
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      stall_inc = 1'b1;
    end else if (branch_taken) begin
      nxt       = FLUSH;
      pc_sel    = 1'b1;
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = (BR_STAGE == 3);
      flush_inc = 1'b1;
    end else if (ld_use || raw) begin
      nxt       = ld_use ? LD_STALL : RAW_STALL;
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_clr  = 1'b1;
      stall_inc = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= nxt;
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
